paddle_input_sequencer: RTL and testbench
=========================================

// Module: paddle_input_sequencer
// PURPOSE
//  Sequences the emulated paddle one-shot for the Breakout core: holds a per-player paddle target,
//  arms on the core's PAD_EN_N pulse, counts scan lines and drives PAD_OUT high until the count
//  reaches the target. Sits between the input mixer (keyboard/joystick/analog/paddle) and
//  breakout_top. Replaces the free-running line counter and the shared digital position register.
// PARAMETERS
//  POS_INIT    114  reset value of both digital position registers
//  DELTA_SLOW  4    digital step per frame, speed=0
//  DELTA_FAST  8    digital step per frame, speed=1
// PORTS
//  clk_sys     in   1  system clock; single clock domain
//  reset       in   1  asynchronous, active-high reset
//  hsync       in   1  core HSYNC, synchronous to clk_sys
//  vsync       in   1  core VSYNC, synchronous to clk_sys
//  pad_en_n    in   1  core PAD_EN_N; low = one-shot trigger
//  player2     in   1  core PLAYER2; selects active player
//  speed       in   1  0 = DELTA_SLOW, 1 = DELTA_FAST
//  p1_mode     in   2  0 digital, 1 absolute, 2 absolute-inverted, 3 hold at POS_INIT
//  p2_mode     in   2  same encoding, player 2
//  p1_left     in   1  p1 move left (position increases)
//  p1_right    in   1  p1 move right (position decreases)
//  p2_left     in   1  p2 move left
//  p2_right    in   1  p2 move right
//  p1_abs      in   8  p1 absolute position from analog/paddle mixer
//  p2_abs      in   8  p2 absolute position
//  pad_out     out  1  to breakout_top PAD_OUT
//  pos_lat     out  8  target latched for the current one-shot
//  busy        out  1  high in COUNT state
// BEHAVIOUR
//  - Reset: both digital pos = POS_INIT; pos_lat = POS_INIT; line cnt = 0; state IDLE; pad_out = 0;
//    busy = 0; hsync/vsync edge registers = 0.
//  - Edges: hs_rise/vs_rise = input & ~registered previous; each acts for exactly one clk_sys cycle.
//  - Digital pos (9-bit arithmetic, saturating 0..255), updated on vs_rise only:
//    left only -> min(pos+delta,255); right only -> max(pos-delta,0); both or neither -> hold.
//    Only the active player's register updates (player2=0 -> p1, player2=1 -> p2);
//    inactive player's inputs are ignored.
//  - Target sel for active player: mode0 digital pos; mode1 ~abs; mode2 abs; mode3 POS_INIT.
//  - FSM:
//    IDLE  -> ARM on pad_en_n==0.
//    ARM   : cnt<=0; pos_lat<=target (sampled every cycle in ARM); pad_out=0; -> COUNT when pad_en_n==1.
//    COUNT : on hs_rise cnt<=cnt+1 (saturates at 255); -> DONE when cnt==pos_lat;
//            pad_en_n==0 -> ARM (restart).
//    DONE  : pad_out=0; -> ARM on pad_en_n==0.
//  - pad_out registered: 1 iff next state is COUNT and next cnt < pos_lat; thus pos_lat==0 yields
//    pad_out never high and COUNT exits to DONE on the first cycle.
//    Latency: pad_out rises 1 clk after pad_en_n rises; falls on the cycle cnt reaches pos_lat.
//  - Simultaneous hs_rise and pad_en_n==0 in COUNT: restart wins, count not incremented.
//  - player2 or mode change during COUNT: no effect on pos_lat until next ARM.
//  - vs_rise during COUNT: digital pos updates; pos_lat unaffected.
//  - Async reset mid-COUNT: pad_out drops immediately; FSM resumes at IDLE.
// STRUCTURE
//  - paddle_pkg: typedef enum logic [1:0] {IDLE,ARM,COUNT,DONE} pad_state_t;
//    typedef enum logic [1:0] {MODE_DIG,MODE_ABS,MODE_ABS_INV,MODE_HOLD} pad_mode_t;
//    localparams POS_MAX=255.
//  - Sub-module paddle_digital_pos (saturating +/-delta register with enable), one per player.
//  - Top: edge detectors, target mux, FSM, 8-bit line counter, registered pad_out.
// TESTING
//  - Reset, mode0, no input, pad_en_n pulse low then high, 200 hsyncs
//    -> pad_out high for exactly 114 hs_rise, then 0; pos_lat=114.
//  - p1 mode0, speed=1, left held 20 vsyncs -> p1 pos 114+160=274 saturates 255;
//    then right held 40 vsyncs -> 0; one-shot gives pad_out 0.
//  - player2=1, p1_left held, p2_right held 3 vsyncs speed=0
//    -> p1 pos stays 114, p2 pos 102; pos_lat=102 on next ARM.
//  - p1 mode1, p1_abs=0x40 -> pos_lat=0xBF; mode2 -> 0x40; pad_out width matches in hs_rise.
//  - Mid-COUNT (cnt=50) pad_en_n pulsed low with coincident hs_rise -> ARM, cnt=0, pad_out=0;
//    full width recounted.
//  - Reset asserted at cnt=30 -> pad_out=0 same cycle; after release, state IDLE,
//    pos registers = 114.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and helpers for the emulated paddle one-shot sequencer.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        DONE
    } pad_state_t;

    // MODE_ABS inverts the mixer value because the core's one-shot width runs
    // opposite to the analog sense; MODE_ABS_INV passes it straight through.
    typedef enum logic [1:0] {
        MODE_DIG,
        MODE_ABS,
        MODE_ABS_INV,
        MODE_HOLD
    } pad_mode_t;

    localparam logic [7:0] POS_MAX = 8'd255;

    // One saturating step of a paddle position, done in 9 bits so the carry
    // or borrow out tells us directly whether we hit the rail.
    function automatic logic [7:0] sat_step(input logic [7:0] pos,
                                            input logic [7:0] delta,
                                            input logic       up);
        logic [8:0] wide;
        if (up) begin
            wide = {1'b0, pos} + {1'b0, delta};
            return wide[8] ? POS_MAX : wide[7:0];
        end
        wide = {1'b0, pos} - {1'b0, delta};
        return wide[8] ? 8'd0 : wide[7:0];
    endfunction

endpackage

// File: rtl/paddle_digital_pos.sv
// Digital paddle position for one player: saturating +/-delta per enabled frame.
module paddle_digital_pos
    import paddle_pkg::*;
#(
    parameter logic [7:0] POS_INIT   = 8'd114,
    parameter logic [7:0] DELTA_SLOW = 8'd4,
    parameter logic [7:0] DELTA_FAST = 8'd8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       en,
    input  logic       speed,
    input  logic       left,
    input  logic       right,
    output logic [7:0] pos
);

    logic [7:0] delta;

    assign delta = speed ? DELTA_FAST : DELTA_SLOW;

    // Step once per enabled frame; left and right together cancel out.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pos <= POS_INIT;
        end else if (en && (left ^ right)) begin
            // NOTE: state is always updated with <= so every register samples
            // the pre-edge values of its inputs, regardless of block order.
            pos <= sat_step(pos, delta, left);
        end
    end

endmodule

// File: rtl/paddle_input_sequencer.sv
// Paddle one-shot sequencer: per-player targets, PAD_EN_N-armed line counter,
// registered PAD_OUT that stays high until the line count reaches the target.
module paddle_input_sequencer
    import paddle_pkg::*;
#(
    parameter logic [7:0] POS_INIT   = 8'd114,
    parameter logic [7:0] DELTA_SLOW = 8'd4,
    parameter logic [7:0] DELTA_FAST = 8'd8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pad_en_n,
    input  logic       player2,
    input  logic       speed,
    input  logic [1:0] p1_mode,
    input  logic [1:0] p2_mode,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic [7:0] p1_abs,
    input  logic [7:0] p2_abs,
    output logic       pad_out,
    output logic [7:0] pos_lat,
    output logic       busy
);

    pad_state_t state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] pos_lat_next;
    logic       pad_out_next;
    logic       hs_prev, vs_prev;
    logic       hs_rise, vs_rise;
    logic [7:0] p1_pos, p2_pos;
    pad_mode_t  act_mode;
    logic [7:0] act_abs, act_dig;
    logic [7:0] target;

    assign hs_rise = hsync & ~hs_prev;
    assign vs_rise = vsync & ~vs_prev;

    // Only the active player's digital register moves; the other one is frozen.
    paddle_digital_pos #(
        .POS_INIT   (POS_INIT),
        .DELTA_SLOW (DELTA_SLOW),
        .DELTA_FAST (DELTA_FAST)
    ) u_p1_pos (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (vs_rise & ~player2),
        .speed   (speed),
        .left    (p1_left),
        .right   (p1_right),
        .pos     (p1_pos)
    );

    paddle_digital_pos #(
        .POS_INIT   (POS_INIT),
        .DELTA_SLOW (DELTA_SLOW),
        .DELTA_FAST (DELTA_FAST)
    ) u_p2_pos (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (vs_rise & player2),
        .speed   (speed),
        .left    (p2_left),
        .right   (p2_right),
        .pos     (p2_pos)
    );

    assign act_mode = pad_mode_t'(player2 ? p2_mode : p1_mode);
    assign act_abs  = player2 ? p2_abs : p1_abs;
    assign act_dig  = player2 ? p2_pos : p1_pos;

    // Target for the active player, chosen by its input mode.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        target = POS_INIT;
        case (act_mode)
            MODE_DIG:     target = act_dig;
            MODE_ABS:     target = ~act_abs;
            MODE_ABS_INV: target = act_abs;
            MODE_HOLD:    target = POS_INIT;
            default:      target = POS_INIT;
        endcase
    end

    // One-shot FSM: next state, next line count, next latched target, next PAD_OUT.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pos_lat_next = pos_lat;
        case (state)
            IDLE: begin
                if (!pad_en_n) state_next = ARM;
            end
            ARM: begin
                cnt_next     = 8'd0;
                pos_lat_next = target;
                if (pad_en_n) state_next = COUNT;
            end
            COUNT: begin
                // A new trigger outranks a coincident line edge.
                if (!pad_en_n) begin
                    state_next = ARM;
                    cnt_next   = 8'd0;
                end else if (cnt == pos_lat) begin
                    state_next = DONE;
                end else if (hs_rise && (cnt != POS_MAX)) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DONE: begin
                if (!pad_en_n) state_next = ARM;
            end
            default: state_next = IDLE;
        endcase
        pad_out_next = (state_next == COUNT) && (cnt_next < pos_lat_next);
    end

    // State, counter, latched target, registered PAD_OUT and edge history.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            pos_lat <= POS_INIT;
            pad_out <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pos_lat <= pos_lat_next;
            pad_out <= pad_out_next;
            hs_prev <= hsync;
            vs_prev <= vsync;
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_paddle_input_sequencer.sv
// Scoreboard bench for paddle_input_sequencer: the driver pushes the expected
// latched target and one-shot width per trigger; the monitor measures each
// one-shot (PAD_OUT-high line edges) and compares when it ends.
module tb_paddle_input_sequencer;

    logic       clk_sys;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       pad_en_n;
    logic       player2;
    logic       speed;
    logic [1:0] p1_mode;
    logic [1:0] p2_mode;
    logic       p1_left;
    logic       p1_right;
    logic       p2_left;
    logic       p2_right;
    logic [7:0] p1_abs;
    logic [7:0] p2_abs;
    logic       pad_out;
    logic [7:0] pos_lat;
    logic       busy;

    paddle_input_sequencer dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .hsync    (hsync),
        .vsync    (vsync),
        .pad_en_n (pad_en_n),
        .player2  (player2),
        .speed    (speed),
        .p1_mode  (p1_mode),
        .p2_mode  (p2_mode),
        .p1_left  (p1_left),
        .p1_right (p1_right),
        .p2_left  (p2_left),
        .p2_right (p2_right),
        .p1_abs   (p1_abs),
        .p2_abs   (p2_abs),
        .pad_out  (pad_out),
        .pos_lat  (pos_lat),
        .busy     (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int lat;
        int width;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    int   tmo_cnt  = 0;
    bit   end_req  = 0;
    int   mdl_pos[2];

    // ---------------------------------------------------------------- monitor
    bit busy_q    = 0;
    bit hs_q      = 0;
    bit hs_r      = 0;
    bit end_done  = 0;
    int width     = 0;
    int lat_seen  = 0;
    int tmo_seen  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        check("shot_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pos_lat", lat_seen, e.lat);
            check("pad_width", width, e.width);
        end
        done_cnt++;
        width = 0;
    endtask

    always @(negedge clk_sys) begin
        if (reset) begin
            check("rst_pad_out", int'(pad_out), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_pos_lat", int'(pos_lat), 114);
            if (busy_q) pop_cmp();
            busy_q = 0;
            hs_q   = 0;
            width  = 0;
        end else begin
            hs_r = hsync & ~hs_q;
            hs_q = hsync;
            if (pad_out) check("pad_out_outside_count", int'(busy), 1);
            if (busy) lat_seen = int'(pos_lat);
            if (pad_out && hs_r && pad_en_n) width++;
            if (busy_q && !busy) pop_cmp();
            busy_q = busy;
        end
        if (tmo_cnt != tmo_seen) begin
            check("shot_timeouts", tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (end_req && !end_done) begin
            check("leftover_expectations", exp_q.size(), 0);
            end_done = 1;
        end
    end

    // ----------------------------------------------------------------- model
    function automatic int model_target();
        int         p;
        logic [1:0] m;
        int         a;
        p = int'(player2);
        m = player2 ? p2_mode : p1_mode;
        a = int'(player2 ? p2_abs : p1_abs);
        case (m)
            2'd0:    return mdl_pos[p];
            2'd1:    return 255 - a;
            2'd2:    return a;
            default: return 114;
        endcase
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic vs_pulse();
        int   p;
        int   d;
        logic l;
        logic r;
        p = int'(player2);
        l = player2 ? p2_left : p1_left;
        r = player2 ? p2_right : p1_right;
        d = speed ? 8 : 4;
        if (l && !r) mdl_pos[p] = (mdl_pos[p] + d > 255) ? 255 : mdl_pos[p] + d;
        else if (r && !l) mdl_pos[p] = (mdl_pos[p] - d < 0) ? 0 : mdl_pos[p] - d;
        vsync = 1'b1;
        cyc();
        vsync = 1'b0;
        cyc();
    endtask

    task automatic hs_pulse();
        hsync = 1'b1;
        cyc();
        hsync = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic fire();
        pad_en_n = 1'b0;
        cyc();
        cyc();
        pad_en_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic push(input int lat, input int w);
        exp_t e;
        e.lat   = lat;
        e.width = w;
        exp_q.push_back(e);
    endtask

    task automatic scramble();
        player2  = 1'($urandom_range(1));
        speed    = 1'($urandom_range(1));
        p1_mode  = 2'($urandom_range(3));
        p2_mode  = 2'($urandom_range(3));
        p1_left  = 1'($urandom_range(1));
        p1_right = 1'($urandom_range(1));
        p2_left  = 1'($urandom_range(1));
        p2_right = 1'($urandom_range(1));
        p1_abs   = 8'($urandom_range(255));
        p2_abs   = 8'($urandom_range(255));
    endtask

    task automatic wait_done(input int goal, input bit scr);
        int n;
        n = 0;
        while (done_cnt < goal && n < 300) begin
            if (scr && $urandom_range(7) == 0) scramble();
            if (scr && $urandom_range(9) == 0) vs_pulse();
            hs_pulse();
            n++;
        end
        repeat (4) cyc();
        if (done_cnt < goal) tmo_cnt++;
    endtask

    task automatic shot(input bit scr);
        int base;
        int t;
        base = done_cnt;
        t    = model_target();
        push(t, t);
        fire();
        wait_done(base + 1, scr);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        hsync    = 1'b0;
        vsync    = 1'b0;
        pad_en_n = 1'b1;
        mdl_pos[0] = 114;
        mdl_pos[1] = 114;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        reset    = 1'b1;
        hsync    = 1'b0;
        vsync    = 1'b0;
        pad_en_n = 1'b1;
        player2  = 1'b0;
        speed    = 1'b0;
        p1_mode  = 2'd0;
        p2_mode  = 2'd0;
        p1_left  = 1'b0;
        p1_right = 1'b0;
        p2_left  = 1'b0;
        p2_right = 1'b0;
        p1_abs   = 8'd0;
        p2_abs   = 8'd0;
        apply_reset();

        // Default target after reset.
        shot(0);

        // p1 digital, fast: saturate high, then low.
        speed   = 1'b1;
        p1_left = 1'b1;
        repeat (20) vs_pulse();
        p1_left = 1'b0;
        shot(0);
        p1_right = 1'b1;
        repeat (40) vs_pulse();
        p1_right = 1'b0;
        shot(0);

        // Only the active player's inputs move its register.
        apply_reset();
        player2  = 1'b1;
        speed    = 1'b0;
        p1_left  = 1'b1;
        p2_right = 1'b1;
        repeat (3) vs_pulse();
        p1_left  = 1'b0;
        p2_right = 1'b0;
        shot(0);
        player2 = 1'b0;
        shot(0);

        // Absolute modes and hold.
        p1_abs  = 8'h40;
        p1_mode = 2'd1;
        shot(0);
        p1_mode = 2'd2;
        shot(0);
        p1_mode = 2'd3;
        shot(0);
        p1_mode = 2'd0;

        // Restart at cnt=50 with a coincident line edge, then full recount.
        base = done_cnt;
        t    = model_target();
        push(t, 50);
        push(t, t);
        fire();
        repeat (50) hs_pulse();
        hsync    = 1'b1;
        pad_en_n = 1'b0;
        cyc();
        hsync    = 1'b0;
        pad_en_n = 1'b1;
        cyc();
        cyc();
        wait_done(base + 2, 0);

        // Asynchronous reset at cnt=30.
        t = model_target();
        push(t, 30);
        fire();
        repeat (30) hs_pulse();
        apply_reset();
        player2 = 1'b0;
        shot(0);
        player2 = 1'b1;
        p2_mode = 2'd0;
        shot(0);

        // Randomized traffic, inputs disturbed while counting.
        repeat (20) begin
            scramble();
            if ($urandom_range(1) == 0) p1_mode = 2'd0;
            if ($urandom_range(1) == 0) p2_mode = 2'd0;
            repeat ($urandom_range(5)) begin
                p1_left  = 1'($urandom_range(1));
                p1_right = 1'($urandom_range(1));
                p2_left  = 1'($urandom_range(1));
                p2_right = 1'($urandom_range(1));
                vs_pulse();
            end
            shot(1);
        end

        end_req = 1'b1;
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
